sram_port_ctrl: RTL and testbench
=================================

# sram_port_ctrl

Requester-side controller for the single-port RW0 SRAM macros (one shared address/enable/write-mode port, 1-cycle registered-address read). It accepts independent valid/ready write and read request streams, arbitrates them onto the single port, and clears the whole array after reset. Read data is returned through a credit-protected response buffer, so consumers can apply backpressure without losing data. One instance sits in front of each data/tag array macro.

## Interface
- ADDR_W, default 7: address width.
- DATA_W, default 8: data width.
- DEPTH, default 128: entries cleared at init (≤ 2^ADDR_W).
- RESP_DEPTH, default 3: response buffer entries; 3 sustains one read per cycle.
- INIT_ON_RESET, default 1: 1 = zero-fill the array after reset; 0 = go straight to RUN.
- clock  in  1  sole clock; the macro's RW0_clk is driven from the same net.
- reset  in  1  asynchronous, active-high.
- w_valid / w_ready  in / out  1  write request handshake.
- w_addr  in  ADDR_W  write address.
- w_data  in  DATA_W  write data.
- r_valid / r_ready  in / out  1  read request handshake.
- r_addr  in  ADDR_W  read address.
- resp_valid / resp_ready  out / in  1  read response handshake.
- resp_data  out  DATA_W  read data, in request order.
- init_done  out  1  high once state is RUN.
- sram_en, sram_wmode  out  1  to RW0_en, RW0_wmode.
- sram_addr  out  ADDR_W  to RW0_addr.
- sram_wdata  out  DATA_W  to RW0_wdata.
- sram_rdata  in  DATA_W  from RW0_rdata.

## Operation
- States: INIT and RUN. Reset enters INIT (or RUN if INIT_ON_RESET=0).
- INIT: an init counter 0..DEPTH-1 issues one write per cycle with wdata=0. Move to RUN on the edge that issues entry DEPTH-1. w_ready and r_ready are 0 in INIT.
- All sram_* outputs are registered. A request accepted in cycle N drives the port in cycle N+1.
- Read credit: rcred = (s1 + s2 + count − pop) < RESP_DEPTH.
  - s1: read presented on the port this cycle.
  - s2: read whose data is on sram_rdata this cycle.
  - count: buffer occupancy.
  - pop = resp_valid & resp_ready.
- Arbitration uses a last_grant bit (reset value = read, so writes win first).
  - w_ready = RUN & (!r_valid | !rcred | last_grant==read).
  - r_ready = RUN & rcred & (!w_valid | last_grant==write).
  - last_grant updates on every accepted request.
  - No ready depends combinationally on its own valid.
- Response path:
  - In the cycle s2 is set, sram_rdata is pushed into the buffer.
  - Buffer head drives resp_data. resp_valid = count≠0.
  - Responses are strictly FIFO.
  - Push and pop in the same cycle are legal and leave count unchanged.
- Hazards: a write accepted before a read to the same address is ordered ahead of it on the port, so the read returns the new data. No forwarding is needed.
- Address width: sram_addr is the accepted address unmodified. The init counter is ADDR_W+1 bits so DEPTH=2^ADDR_W terminates without wrap-around.

## Timing
- Reset values: state=INIT (or RUN), sram_en=0, sram_wmode=0, sram_addr=0, sram_wdata=0, s1=s2=0, count=0, resp_valid=0, init_done=0 (1 if INIT_ON_RESET=0).
- Init timing, with cycle 0 = first cycle with reset low:
  - Init writes appear on the port in cycles 1..DEPTH, at addresses 0..DEPTH-1.
  - init_done=1 and requests are accepted from cycle DEPTH.
- Write: accepted in N, port write in N+1; the macro updates at the end of N+1.
- Read: accepted in N, port read in N+1, sram_rdata valid in N+2, resp_valid in N+3 at the earliest. Minimum latency is 3.
- Throughput: one request per cycle in total. Reads run at one per cycle when resp_ready is held at 1 and RESP_DEPTH≥3.
- Reset mid-operation (asserted asynchronously at any point):
  - Drops s1, s2 and buffer contents. resp_valid falls immediately.
  - Forces sram_en=0.
  - Re-runs INIT from address 0 after release. Requests in flight are lost, with no response.

## Structure
- Package sram_ctrl_pkg: the state enum (INIT, RUN), the grant enum (GRANT_W, GRANT_R), and the default widths/depths as localparams.
- One sub-module, sram_resp_fifo: a RESP_DEPTH-entry synchronous FIFO with push/pop/count/head, reset-cleared pointers, and no data reset.
- The arbiter, credit logic, init counter and port registers live in sram_port_ctrl.

## Test plan
- Init: release reset with defaults → sram_en=1, wmode=1, wdata=0 in cycles 1..128 at addresses 0..127; init_done=1 at cycle 128; reads of 0x00, 0x40 and 0x7F return 0x00.
- Write then read: write 0x5A to 0x11 in cycle N, read 0x11 in N+1 → resp_data=0x5A with resp_valid first high in cycle N+4.
- Contention: w_valid and r_valid both held high with resp_ready=1 → grants alternate W,R,W,R (write first after reset); each accepted read returns that address's data.
- Backpressure: resp_ready=0, 5 reads offered → exactly 3 accepted, then r_ready=0. With resp_ready=1, the 3 responses arrive in order and the remaining 2 reads are accepted.
- Throughput: write addr a with data ~a for a=0..9, then 10 back-to-back reads with resp_ready=1 → r_ready stays 1 and resp_data = 0xFF, 0xFE, … 0xF6 on consecutive cycles.
- Reset mid-operation: assert reset with 2 reads in flight and 1 buffered → resp_valid=0 and sram_en=0 immediately; after release, init restarts at address 0 and no stale response appears.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizing for the RW0 SRAM port controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    GRANT_W = 1'b0,
    GRANT_R = 1'b1
  } grant_t;

  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_DEPTH      = 128;
  localparam int DEF_RESP_DEPTH = 3;

endpackage

// File: rtl/sram_resp_fifo.sv
// Read-response buffer: small synchronous FIFO, head visible combinationally.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; the caller's credit scheme guarantees no overflow.
module sram_resp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 3,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head = mem[rd_ptr];

  // Storage is deliberately not reset; only pointers and count are.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// Arbitrates write/read request streams onto one RW0 SRAM port and zero-fills the array after reset.
// Latency: request accepted in N drives the port in N+1; read response valid in N+3 at the earliest.
// Backpressure: reads are credit-limited by the response buffer; writes/reads alternate under contention.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int RESP_DEPTH    = DEF_RESP_DEPTH,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 2;
  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;

  state_t            state, next_state;
  grant_t            last_grant;
  logic [ADDR_W:0]   init_cnt;     // one extra bit so DEPTH = 2^ADDR_W ends cleanly
  logic              last_init;
  logic              s1, s2;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic [OCC_W-1:0]  occ;
  logic              rcred;
  logic              w_acc, r_acc;

  assign last_init  = (init_cnt == (ADDR_W + 1)'(DEPTH - 1));
  assign s1         = sram_en & ~sram_wmode;
  assign resp_valid = (count != '0);
  assign pop        = resp_valid & resp_ready;
  assign occ        = OCC_W'(s1) + OCC_W'(s2) + OCC_W'(count) - OCC_W'(pop);
  assign rcred      = (occ < OCC_W'(RESP_DEPTH));
  assign w_acc      = w_valid & w_ready;
  assign r_acc      = r_valid & r_ready;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RESET_STATE;
    else       state <= next_state;
  end

  // Next state and request readies; readies never look at their own valid.
  always_comb begin
    next_state = state;
    w_ready    = 1'b0;
    r_ready    = 1'b0;
    init_done  = 1'b0;
    if (state == INIT) begin
      if (last_init) next_state = RUN;
    end else begin
      init_done = 1'b1;
      w_ready   = !r_valid || !rcred || (last_grant == GRANT_R);
      r_ready   = rcred && (!w_valid || (last_grant == GRANT_W));
    end
  end

  // Init address counter, advances once per cycle while clearing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               init_cnt <= '0;
    else if (state == INIT)  init_cnt <= init_cnt + (ADDR_W + 1)'(1);
  end

  // Fairness bit: remembers which stream won the last accepted request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      last_grant <= GRANT_R;
    else if (w_acc) last_grant <= GRANT_W;
    else if (r_acc) last_grant <= GRANT_R;
  end

  // Registered SRAM port: init writes, then accepted requests in acceptance order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sram_en    <= 1'b0;
      sram_wmode <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else if (state == INIT) begin
      sram_en    <= 1'b1;
      sram_wmode <= 1'b1;
      sram_addr  <= init_cnt[ADDR_W-1:0];
      sram_wdata <= '0;
    end else if (w_acc) begin
      sram_en    <= 1'b1;
      sram_wmode <= 1'b1;
      sram_addr  <= w_addr;
      sram_wdata <= w_data;
    end else if (r_acc) begin
      sram_en    <= 1'b1;
      sram_wmode <= 1'b0;
      sram_addr  <= r_addr;
    end else begin
      sram_en    <= 1'b0;
      sram_wmode <= 1'b0;
    end
  end

  // s2 marks the cycle the macro presents data for the read issued last cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) s2 <= 1'b0;
    else       s2 <= s1;
  end

  sram_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (s2),
    .push_data (sram_rdata),
    .pop       (pop),
    .count     (count),
    .head      (resp_data)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl with a behavioural RW0 macro and a request-order scoreboard.
// Latency: n/a.
// Backpressure: resp_ready driven by the directed and random phases.
module tb_sram_port_ctrl;

  logic       clock, reset;
  logic       w_valid, w_ready, r_valid, r_ready;
  logic [6:0] w_addr, r_addr, sram_addr;
  logic [7:0] w_data, resp_data, sram_wdata, sram_rdata;
  logic       resp_valid, resp_ready, init_done, sram_en, sram_wmode;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem     [128];   // macro contents
  logic [7:0] ref_mem [128];   // what the array should hold, per accepted write order
  logic [7:0] exp_q   [$];     // expected responses, in read acceptance order
  logic [7:0] resp_log[$];
  int         resp_cyc[$];
  bit         grant_log[$];    // 0 = write accepted, 1 = read accepted
  logic [7:0] mon_e;

  sram_port_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_addr     (r_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Single-port macro with a registered-address read.
  always @(posedge clock) begin
    if (sram_en && sram_wmode)  mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every accepted read must come back once, in order, with the latest written value.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    end else begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("resp_spurious", 32'(resp_valid), 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("resp_data", 32'(resp_data), 32'(mon_e));
        end
        resp_log.push_back(resp_data);
        resp_cyc.push_back(cyc);
      end
      if (w_valid && w_ready) begin
        ref_mem[w_addr] = w_data;
        grant_log.push_back(1'b0);
      end
      if (r_valid && r_ready) begin
        exp_q.push_back(ref_mem[r_addr]);
        grant_log.push_back(1'b1);
      end
    end
  end

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  // Entered in cycle 0 (first cycle with reset low); returns at the sample point of cycle 128.
  task automatic check_init;
    logic [20:0] got, exp;
    for (int c = 0; c <= 128; c++) begin
      @(negedge clock);
      got = {sram_en, sram_wmode, sram_addr, sram_wdata, init_done, resp_valid, w_ready, r_ready};
      if (c == 0) exp = '0;
      else exp = {1'b1, 1'b1, 7'(c - 1), 8'h00, (c == 128), 1'b0, (c == 128), (c == 128)};
      chk("init_port", 32'(got), 32'(exp));
      if (c < 128) next_cycle;
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    w_valid = 1'b1; w_addr = a; w_data = d;
    @(negedge clock);
    while (!w_ready && n < 50) begin next_cycle; @(negedge clock); n++; end
    chk("wr_accept_bound", 32'(n < 50), 32'd1);
    next_cycle;
    w_valid = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a);
    int n = 0;
    r_valid = 1'b1; r_addr = a;
    @(negedge clock);
    while (!r_ready && n < 50) begin next_cycle; @(negedge clock); n++; end
    chk("rd_accept_bound", 32'(n < 50), 32'd1);
    next_cycle;
    r_valid = 1'b0;
  endtask

  task automatic drain;
    resp_ready = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clock);
      if (exp_q.size() == 0) break;
      next_cycle;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    next_cycle;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_rd, lat, n_acc;
    logic [7:0] got_d;
    logic acc;

    w_valid = 0; r_valid = 0; resp_ready = 0;
    w_addr = 0; r_addr = 0; w_data = 0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_state", 32'({sram_en, sram_wmode, sram_addr, sram_wdata, resp_valid,
                            init_done, w_ready, r_ready}), 32'd0);

    // Zero-fill after reset, then spot-check cleared locations.
    @(posedge clock); #1;
    reset = 1'b0;
    check_init();
    next_cycle;
    resp_ready = 1'b1;
    do_read(7'h00); do_read(7'h40); do_read(7'h7F);
    drain();

    // Write followed immediately by a read of the same address.
    w_valid = 1'b1; w_addr = 7'h11; w_data = 8'h5A;
    @(negedge clock); chk("hz_w_ready", 32'(w_ready), 32'd1);
    next_cycle;
    w_valid = 1'b0; r_valid = 1'b1; r_addr = 7'h11;
    @(negedge clock); chk("hz_r_ready", 32'(r_ready), 32'd1);
    t_rd = cyc;
    next_cycle;
    r_valid = 1'b0;
    lat = -1; got_d = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (resp_valid) begin lat = cyc - t_rd; got_d = resp_data; break; end
      next_cycle;
    end
    chk("hz_latency", 32'(lat), 32'd3);
    chk("hz_data", 32'(got_d), 32'h5A);
    next_cycle;
    drain();

    // Contention: both streams valid every cycle.
    grant_log.delete();
    w_valid = 1'b1; r_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w_addr = 7'($urandom_range(0, 7)); w_data = 8'($urandom); r_addr = 7'($urandom_range(0, 7));
      @(negedge clock);
      next_cycle;
    end
    w_valid = 1'b0; r_valid = 1'b0;
    chk("contend_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < grant_log.size(); k++) chk("contend_order", 32'(grant_log[k]), 32'(k % 2));
    drain();

    // Backpressure: 5 reads offered with responses stalled.
    resp_log.delete();
    resp_ready = 1'b0; r_valid = 1'b1; r_addr = 7'($urandom); n_acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      acc = r_ready;
      if (acc) n_acc++;
      next_cycle;
      if (acc) r_addr = 7'($urandom);
      if (n_acc >= 5) r_valid = 1'b0;
    end
    chk("bp_accepted", 32'(n_acc), 32'd3);
    @(negedge clock);
    chk("bp_r_ready_low", 32'(r_ready), 32'd0);
    next_cycle;
    resp_ready = 1'b1;
    for (int k = 0; k < 20 && n_acc < 5; k++) begin
      @(negedge clock);
      acc = r_ready;
      if (acc) n_acc++;
      next_cycle;
      if (acc) r_addr = 7'($urandom);
    end
    r_valid = 1'b0;
    chk("bp_total", 32'(n_acc), 32'd5);
    drain();
    chk("bp_resp_count", 32'(resp_log.size()), 32'd5);

    // Throughput: back-to-back reads of freshly written data.
    for (int a = 0; a < 10; a++) do_write(7'(a), 8'(8'hFF - a));
    resp_log.delete(); resp_cyc.delete();
    resp_ready = 1'b1; r_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r_addr = 7'(i);
      @(negedge clock);
      chk("tp_r_ready", 32'(r_ready), 32'd1);
      next_cycle;
    end
    r_valid = 1'b0;
    drain();
    chk("tp_count", 32'(resp_log.size()), 32'd10);
    for (int i = 0; i < resp_log.size(); i++) begin
      chk("tp_data", 32'(resp_log[i]), 32'(8'hFF - i));
      chk("tp_spacing", 32'(resp_cyc[i] - resp_cyc[0]), 32'(i));
    end

    // Reset with two reads in flight and one buffered.
    resp_ready = 1'b0; r_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r_addr = 7'(20 + k);
      @(negedge clock);
      chk("mo_r_ready", 32'(r_ready), 32'd1);
      next_cycle;
    end
    r_valid = 1'b0;
    @(negedge clock);
    chk("mo_pre_state", 32'({resp_valid, sram_en, sram_wmode}), 32'b110);
    #2 reset = 1'b1;
    #1;
    chk("mo_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mo_rst_sram_en", 32'(sram_en), 32'd0);
    resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_init();
    next_cycle;

    // Random mixed traffic over a small address window to provoke hazards.
    for (int k = 0; k < 400; k++) begin
      w_valid    = 1'($urandom_range(0, 1));
      r_valid    = 1'($urandom_range(0, 1));
      resp_ready = ($urandom_range(0, 3) != 0);
      w_addr     = 7'($urandom_range(0, 7));
      w_data     = 8'($urandom);
      r_addr     = 7'($urandom_range(0, 7));
      next_cycle;
    end
    w_valid = 1'b0; r_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
